// File: rtl/synapse_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : synapse_event_arbiter
// Description : N-source round-robin event arbiter with burst grants and a
//               registered single-entry output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_event_arbiter #(
    parameter  int N         = 4,
    parameter  int W         = 32,
    parameter  int MAX_BURST = 4,
    localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    input  logic [N-1:0]   req_v,
    output logic [N-1:0]   req_r,
    input  logic [N*W-1:0] req_d,
    output logic           out_v,
    input  logic           out_r,
    output logic [W-1:0]   out_d,
    output logic [SW-1:0]  out_src,
    output logic           busy
);

    localparam logic [0:0]    c_IDLE      = 1'b0;
    localparam logic [0:0]    c_GRANT     = 1'b1;
    localparam logic [SW-1:0] c_LAST_INIT = SW'(N - 1);
    localparam logic [7:0]    c_MAX_BURST = 8'(MAX_BURST);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [SW-1:0] r_grant;
    logic [SW-1:0] r_last;
    logic [SW-1:0] w_pick;
    logic [7:0]    r_burst_cnt;
    logic          r_out_v;
    logic [W-1:0]  r_out_d;
    logic [SW-1:0] r_out_src;

    logic          w_slot_free;
    logic          w_grant_ok;
    logic          w_accept;
    logic          w_sel_v;
    logic [W-1:0]  w_sel_d;
    logic          w_any_req;
    logic          w_burst_done;
    logic          w_grant_end;

    assign w_slot_free  = !r_out_v || out_r;
    assign w_any_req    = |req_v;
    assign w_grant_ok   = clk_en && (r_state == c_GRANT) && w_slot_free;
    assign w_accept     = w_grant_ok && w_sel_v;
    assign w_burst_done = w_accept && ((r_burst_cnt + 8'd1) == c_MAX_BURST);
    assign w_grant_end  = w_burst_done || (clk_en && !w_sel_v);

    // Mux out the valid and data of the currently granted source.
    always_comb begin
        w_sel_v = 1'b0;
        w_sel_d = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant == SW'(i)) begin
                w_sel_v = req_v[i];
                w_sel_d = req_d[i*W +: W];
            end
        end
    end

    // Round-robin pick: scanning from the far end lets the nearest requester
    // after 'last' overwrite the others.
    always_comb begin
        int v_idx;
        w_pick = r_last;
        v_idx  = 0;
        for (int k = N; k >= 1; k--) begin
            v_idx = (int'(r_last) + k) % N;
            if (req_v[v_idx]) begin
                w_pick = SW'(v_idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (clk_en && w_any_req) begin
                    w_state_nxt = c_GRANT;
                end
            end
            c_GRANT: begin
                if (w_grant_end) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_last      <= c_LAST_INIT;
            r_burst_cnt <= '0;
        end else if (clk_en) begin
            if (r_state == c_IDLE) begin
                if (w_any_req) begin
                    r_grant     <= w_pick;
                    r_burst_cnt <= '0;
                end
            end else begin
                if (w_accept) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
                if (w_grant_end) begin
                    r_last <= r_grant;
                end
            end
        end
    end

    // Output slot: an accept on the same edge as a pop refills it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v   <= 1'b0;
            r_out_d   <= '0;
            r_out_src <= '0;
        end else if (clk_en) begin
            if (w_accept) begin
                r_out_v   <= 1'b1;
                r_out_d   <= w_sel_d;
                r_out_src <= r_grant;
            end else if (r_out_v && out_r) begin
                r_out_v   <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        req_r = '0;
        for (int i = 0; i < N; i++) begin
            req_r[i] = w_grant_ok && (r_grant == SW'(i));
        end
        busy = (r_state == c_GRANT) || r_out_v;
    end

    assign out_v   = r_out_v;
    assign out_d   = r_out_d;
    assign out_src = r_out_src;

endmodule
`default_nettype wire

// File: doc/synapse_event_arbiter.md
SYNAPSE_EVENT_ARBITER -- requirements
Module: synapse_event_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesting event sources; legal range 2..16.
REQ-002 SHALL have parameter W, default 32: event word width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats accepted per grant; legal range 1..255.
REQ-004 SHALL have derived width SW = max(1, clog2(N)).
REQ-005 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port clk_en, input, 1: state-update enable; clk_en=0 freezes all state.
REQ-008 SHALL have port req_v, input, N: per-source event valid.
REQ-009 SHALL have port req_r, output, N: per-source ready; at most one bit high in any cycle.
REQ-010 SHALL have port req_d, input, N*W: per-source event word; source i occupies bits [i*W +: W].
REQ-011 SHALL have port out_v, input/output as follows: output, 1: merged event valid, registered.
REQ-012 SHALL have port out_r, input, 1: downstream ready.
REQ-013 SHALL have port out_d, output, W: merged event word, registered.
REQ-014 SHALL have port out_src, output, SW: index of the source that produced out_d, registered.
REQ-015 SHALL have port busy, output, 1: high when the FSM is in GRANT or out_v=1.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and GRANT, with registers grant (SW bits), last (SW bits) and burst_cnt (8 bits).
REQ-017 SHALL define slot_free = !out_v || out_r, and accept_i = clk_en && req_v[i] && req_r[i].
REQ-018 SHALL drive req_r[i] = clk_en && (state==GRANT) && (grant==i) && slot_free, combinationally; all req_r bits are 0 in IDLE.
REQ-019 IDLE with clk_en=1 and any req_v high: SHALL select the first requesting index scanning last+1, last+2, ... modulo N; set grant=that index and burst_cnt=0; go to GRANT. This costs one arbitration bubble cycle.
REQ-020 IDLE with no req_v high, or with clk_en=0: SHALL stay in IDLE.
REQ-021 On accept_i: SHALL load out_d=req_d[i] and out_src=i, set out_v=1, and increment burst_cnt, all on the same edge.
REQ-022 When out_v=1, out_r=1, clk_en=1 and no accept occurs: SHALL clear out_v on that edge.
REQ-023 Simultaneous downstream pop and accept: SHALL keep out_v=1 with the new data, giving full throughput of one beat per cycle.
REQ-024 In GRANT: SHALL return to IDLE and set last=grant on the edge where either (a) an accept makes burst_cnt+1 == MAX_BURST, or (b) clk_en=1 and req_v[grant]=0.
REQ-025 A source SHALL NOT be preempted within its burst while its req_v stays high; a source withdrawing valid ends its grant.
REQ-026 req_d, out_src and burst arithmetic SHALL wrap modulo their widths, and last+k SHALL wrap modulo N for non-power-of-two N.
REQ-027 When out_v=1 and out_r=0: out_d and out_src SHALL hold stable and all req_r SHALL be 0, with no data loss.
REQ-028 When clk_en=0: SHALL change no register, including out_v, whatever the values of out_r and req_v.

Reset
REQ-029 While rst_n=0: state=IDLE, grant=0, last=N-1 (so source 0 is served first), burst_cnt=0, out_v=0, out_d=0, out_src=0, busy=0, req_r=0.
REQ-030 Reset asserted mid-burst SHALL take effect immediately and asynchronously; any pending out_d is discarded.
REQ-031 After release, the first grant SHALL occur no earlier than the first clk_en=1 edge following deassertion.

Verification
REQ-032 Single source: req_v=4'b0100, out_r=1, MAX_BURST=4, 6 words -> beats 0..3 appear with out_src=2, then a 1-cycle IDLE bubble, then beats 4..5; order is preserved.
REQ-033 All sources valid continuously, out_r=1 -> grant order is 0,1,2,3,0,... in bursts of 4 with out_src matching; no source waits more than 3 bursts.
REQ-034 Backpressure: out_r=0 for 5 cycles mid-burst -> out_d stable, req_r=0, no word dropped or duplicated; throughput resumes at 1 beat per cycle after out_r=1.
REQ-035 Source 1 drops req_v after 2 beats while source 3 is waiting -> FSM returns to IDLE, next grant goes to 3, and last=1.
REQ-036 clk_en toggles 1,0,1,0 under full load -> state and outputs change only on clk_en=1 edges, and req_r=0 whenever clk_en=0.
REQ-037 rst_n pulsed low during GRANT with out_v=1 -> out_v=0 and req_r=0 immediately; after release the first grant goes to source 0.
